// File: rtl/i2c_bit_ctrl.sv
// I2C bit sequencer: runs one START/STOP/WRITE/READ command through four
// quarter-bit phases, with SCL stretch handling and arbitration-loss abort.
module i2c_bit_ctrl #(
  parameter int QUARTER = 31
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic       cmd_din,
  output logic       done,
  output logic       dout,
  output logic       arb_lost,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

  localparam logic [1:0] C_START = 2'b00;
  localparam logic [1:0] C_STOP  = 2'b01;
  localparam logic [1:0] C_WRITE = 2'b10;
  localparam logic [1:0] C_READ  = 2'b11;

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    cmd_q;
  logic          din_q;
  logic          scl_n, sda_n, done_n, arb_n, dout_n;
  logic          stretch, arb, advance;

  // {scl pull-low, sda pull-low} for a command in a given phase
  function automatic logic [1:0] levels(input logic [1:0] c, input logic d, input state_t ph);
    logic scl_l, sda_l;
    scl_l = 1'b0;
    sda_l = 1'b0;
    case (c)
      C_START: begin
        scl_l = (ph == PH_D);
        sda_l = (ph == PH_C) || (ph == PH_D);
      end
      C_STOP: begin
        scl_l = (ph == PH_A);
        sda_l = (ph != PH_D);
      end
      C_WRITE: begin
        scl_l = (ph == PH_A) || (ph == PH_D);
        sda_l = ~d;
      end
      default: begin
        scl_l = (ph == PH_A) || (ph == PH_D);
        sda_l = 1'b0;
      end
    endcase
    return {scl_l, sda_l};
  endfunction

  always_ff @(posedge CLK) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd_q    <= 2'b00;
      din_q    <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      done     <= 1'b0;
      arb_lost <= 1'b0;
      dout     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      scl_oe   <= scl_n;
      sda_oe   <= sda_n;
      done     <= done_n;
      arb_lost <= arb_n;
      dout     <= dout_n;
      if (state == IDLE && cmd_valid) begin
        cmd_q <= cmd;
        din_q <= cmd_din;
      end
    end
  end

  // Stretch only counts while we release SCL and someone else holds it low
  always_comb begin
    stretch = (state == PH_B) && !scl_i && !scl_oe;
    arb     = (cmd_q == C_WRITE) && din_q && (state == PH_B || state == PH_C)
              && !stretch && !sda_i;
    advance = (state != IDLE) && !stretch && !arb && (cnt == LAST);
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (cmd_valid) state_n = PH_A;
      end
      default: begin
        if (arb) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (!stretch) begin
          if (cnt == LAST) begin
            cnt_n = '0;
            case (state)
              PH_A:    state_n = PH_B;
              PH_B:    state_n = PH_C;
              PH_C:    state_n = PH_D;
              default: state_n = IDLE;
            endcase
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
    endcase
  end

  always_comb begin
    scl_n  = scl_oe;
    sda_n  = sda_oe;
    done_n = 1'b0;
    arb_n  = 1'b0;
    dout_n = dout;
    if (state == IDLE) begin
      if (cmd_valid) {scl_n, sda_n} = levels(cmd, cmd_din, PH_A);
    end else if (arb) begin
      scl_n = 1'b0;
      sda_n = 1'b0;
      arb_n = 1'b1;
    end else if (advance) begin
      if (state == PH_D) done_n = 1'b1;
      else {scl_n, sda_n} = levels(cmd_q, din_q, state_n);
      if (state == PH_C && cmd_q == C_READ) dout_n = sda_i;
    end
  end

  assign busy      = (state != IDLE);
  assign cmd_ready = (state == IDLE);
endmodule

// File: tb/tb_i2c_bit_ctrl.sv
// Bench for i2c_bit_ctrl: timeline model compared every cycle plus directed
// literal checks of reset, START timing, back-to-back, READ, stretch, arbitration.
module tb_i2c_bit_ctrl;
  localparam int Q = 4;

  logic       CLK = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_din = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       scl_i = 1'b1, sda_i = 1'b1;
  logic       cmd_ready, done, dout, arb_lost, busy, scl_oe, sda_oe;
  logic       force_scl = 1'b0, force_sda = 1'b0;
  int         cyc = 0, total = 0, passed = 0;
  logic [3:0] rec [0:2047];

  i2c_bit_ctrl #(.QUARTER(Q)) dut (
    .CLK(CLK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .cmd_din(cmd_din), .done(done), .dout(dout),
    .arb_lost(arb_lost), .busy(busy), .scl_i(scl_i), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // wired-AND bus: a line reads low if the DUT or the bench pulls it
  always @(negedge CLK) begin
    #1;
    scl_i = !scl_oe && !force_scl;
    sda_i = !sda_oe && !force_sda;
  end

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, a, e);
  endtask

  // Model: per-phase line table, time measured in non-stretched cycles since accept
  bit         m_busy, m_din, m_scl, m_sda, m_done, m_arb, m_dout;
  logic [1:0] m_cmd;
  int         m_t;

  function automatic bit [1:0] lvl(input logic [1:0] c, input bit d, input int ph);
    bit [3:0] s, a;
    case (c)
      2'd0:    begin s = 4'b1000; a = 4'b1100; end
      2'd1:    begin s = 4'b0001; a = 4'b0111; end
      2'd2:    begin s = 4'b1001; a = d ? 4'b0000 : 4'b1111; end
      default: begin s = 4'b1001; a = 4'b0000; end
    endcase
    return {s[ph], a[ph]};
  endfunction

  always @(posedge CLK) begin : model
    int ph;
    bit st, ab;
    m_done = 0;
    m_arb  = 0;
    if (rst) begin
      m_busy = 0; m_scl = 0; m_sda = 0; m_dout = 0; m_t = 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        m_busy = 1; m_cmd = cmd; m_din = cmd_din; m_t = 0;
        {m_scl, m_sda} = lvl(cmd, cmd_din, 0);
      end
    end else begin
      ph = m_t / Q;
      st = (ph == 1) && !scl_i && !m_scl;
      ab = (m_cmd == 2'd2) && m_din && (ph == 1 || ph == 2) && !st && !sda_i;
      if (ab) begin
        m_busy = 0; m_scl = 0; m_sda = 0; m_arb = 1;
      end else if (!st) begin
        if (m_cmd == 2'd3 && m_t == 3*Q-1) m_dout = sda_i;
        m_t++;
        if (m_t == 4*Q) begin
          m_busy = 0; m_done = 1;
        end else begin
          {m_scl, m_sda} = lvl(m_cmd, m_din, m_t / Q);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      chk($sformatf("cycle%0d", cyc),
          {25'd0, cmd_ready, busy, scl_oe, sda_oe, done, arb_lost, dout},
          {25'd0, !m_busy, m_busy, m_scl, m_sda, m_done, m_arb, m_dout});
      if (cyc < 2048) rec[cyc] = {scl_oe, sda_oe, done, arb_lost};
    end
  end

  function automatic int count(input int lo, input int hi, input int b);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (rec[c][b]) n++;
    return n;
  endfunction

  function automatic int first_set(input int lo, input int hi, input int b);
    for (int c = lo; c <= hi; c++) if (rec[c][b]) return c;
    return -1;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic issue(input logic [1:0] c, input bit d, output int k);
    int n = 0;
    cmd_valid = 1'b1; cmd = c; cmd_din = d;
    while (!cmd_ready && n < 200) begin @(negedge CLK); n++; end
    chk("accept", {31'd0, cmd_ready}, 32'd1);
    k = cyc;
    @(negedge CLK);
    cmd_valid = 1'b0;
  endtask

  initial begin
    int k, k1, k2, k3;
    repeat (3) @(negedge CLK);
    chk("reset_vals", {cmd_ready, busy, scl_oe, sda_oe, done, arb_lost, dout}, 7'b1000000);
    rst = 1'b0;

    // START accepted at edge 10
    wait_until(10);
    issue(2'd0, 1'b0, k);
    chk("start_k", k, 10);
    wait_until(30);
    chk("start_sda_rise", first_set(11, 29, 2), 19);
    chk("start_scl_rise", first_set(11, 29, 3), 23);
    chk("start_done_cyc", first_set(11, 29, 1), 27);
    chk("start_done_cnt", count(11, 29, 1), 1);
    chk("start_parked", {scl_oe, sda_oe}, 2'b11);

    // reset during PH_C of WRITE 0
    issue(2'd2, 1'b0, k);
    wait_until(k + 10);
    rst = 1'b1;
    @(negedge CLK);
    rst = 1'b0;
    chk("rst_mid", {scl_oe, sda_oe, cmd_ready, done}, 4'b0010);
    wait_until(k + 20);
    chk("rst_mid_no_done", count(k + 1, k + 19, 1), 0);

    // WRITE 0, WRITE 1, STOP back-to-back
    issue(2'd2, 1'b0, k1);
    issue(2'd2, 1'b1, k2);
    issue(2'd1, 1'b0, k3);
    wait_until(k3 + 19);
    chk("b2b_gap1", k2 - k1, 17);
    chk("b2b_gap2", k3 - k2, 17);
    chk("w0_sda", {31'd0, rec[k1 + 8][2]}, 32'd1);
    chk("w1_sda", {31'd0, rec[k2 + 8][2]}, 32'd0);
    chk("b2b_dones", count(k1 + 1, k3 + 18, 1), 3);
    chk("stop_end", {scl_oe, sda_oe}, 2'b00);

    // READ with SDA held low, then released
    force_sda = 1'b1;
    issue(2'd3, 1'b0, k);
    wait_until(k + 18);
    force_sda = 1'b0;
    chk("read0_dout", {31'd0, dout}, 32'd0);
    chk("read0_done", {31'd0, rec[k + 17][1]}, 32'd1);
    issue(2'd3, 1'b0, k);
    wait_until(k + 18);
    chk("read1_dout", {31'd0, dout}, 32'd1);
    chk("read1_done", {31'd0, rec[k + 17][1]}, 32'd1);

    // 10-cycle SCL stretch in PH_B of a WRITE
    issue(2'd2, 1'b0, k);
    wait_until(k + 5);
    force_scl = 1'b1;
    wait_until(k + 15);
    force_scl = 1'b0;
    wait_until(k + 30);
    chk("stretch_done_cyc", first_set(k + 1, k + 29, 1), k + 27);
    chk("stretch_done_cnt", count(k + 1, k + 29, 1), 1);

    // arbitration loss on WRITE 1
    issue(2'd2, 1'b1, k);
    wait_until(k + 5);
    force_sda = 1'b1;
    @(negedge CLK);
    chk("arb_pulse", {arb_lost, cmd_ready, scl_oe, sda_oe}, 4'b1100);
    force_sda = 1'b0;
    wait_until(k + 25);
    chk("arb_cnt", count(k + 1, k + 24, 0), 1);
    chk("arb_no_done", count(k + 1, k + 24, 1), 0);
    chk("arb_released", {scl_oe, sda_oe}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
